// File: rtl/irq_request_latch.sv
// Interrupt request front end: synchronises raw irq lines, latches them as pending,
// masks them for the priority encoder and hands out one grant at a time over valid/ack.
module irq_request_latch #(
  parameter bit EDGE        = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic [7:0] pend_o,
  output logic       pend_any,
  output logic       req_valid,
  output logic [2:0] req_idx
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  function automatic logic [2:0] prio_idx(input logic [7:0] v);
    logic [2:0] idx;
    casez (v)
      8'b1???????: idx = 3'd7;
      8'b01??????: idx = 3'd6;
      8'b001?????: idx = 3'd5;
      8'b0001????: idx = 3'd4;
      8'b00001???: idx = 3'd3;
      8'b000001??: idx = 3'd2;
      8'b0000001?: idx = 3'd1;
      default:     idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [7:0] idx_onehot(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  s_d_q;
  logic [SYNC_STAGES:0]        prime_q;
  logic [7:0]                  pend_q, pend_d;
  logic [7:0]                  pend_o_q;
  logic                        pend_any_q;
  logic                        req_valid_q, req_valid_d;
  logic [2:0]                  req_idx_q, req_idx_d;
  state_t                      state_q, state_d;

  logic [7:0] s_s;
  logic [7:0] rise_s;
  logic [7:0] clr_s;
  logic [7:0] pend_masked_s;

  assign s_s           = sync_q[SYNC_STAGES-1];
  assign pend_masked_s = pend_q & mask;

  // Synchroniser chain, edge-history flop and warm-up shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      s_d_q   <= 8'h00;
      prime_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      s_d_q   <= s_s;
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Rising edges only count once the history flop holds a real sample, so a
  // line already high when reset releases is not mistaken for a new request.
  always_comb begin
    if (prime_q[SYNC_STAGES]) begin
      rise_s = s_s & ~s_d_q;
    end else begin
      rise_s = 8'h00;
    end
  end

  // Grant FSM next state: grant is frozen while presented, one settle cycle after ack.
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_idx_d   = req_idx_q;
    clr_s       = 8'h00;
    case (state_q)
      IDLE: begin
        if (|pend_masked_s) begin
          req_idx_d   = prio_idx(pend_masked_s);
          req_valid_d = 1'b1;
          state_d     = PRESENT;
        end else begin
          req_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      PRESENT: begin
        if (ack) begin
          req_valid_d = 1'b0;
          state_d     = GAP;
          if (EDGE) begin
            clr_s = idx_onehot(req_idx_q);
          end else begin
            clr_s = 8'h00;
          end
        end else begin
          req_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      GAP: begin
        req_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        req_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Pending next state; a coincident set beats the ack clear.
  always_comb begin
    if (EDGE) begin
      pend_d = (pend_q & ~clr_s) | rise_s;
    end else begin
      pend_d = s_s;
    end
  end

  // State, pending and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= 8'h00;
      pend_o_q    <= 8'h00;
      pend_any_q  <= 1'b0;
      req_valid_q <= 1'b0;
      req_idx_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_o_q    <= pend_masked_s;
      pend_any_q  <= |pend_masked_s;
      req_valid_q <= req_valid_d;
      req_idx_q   <= req_idx_d;
    end
  end

  assign pend_o    = pend_o_q;
  assign pend_any  = pend_any_q;
  assign req_valid = req_valid_q;
  assign req_idx   = req_idx_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Scoreboard bench for irq_request_latch: an edge-mode instance and a level-mode
// instance; grants are checked by monitors against queued expectations.
module tb_irq_request_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in, mask;
  logic       ack;
  logic [7:0] pend_o;
  logic       pend_any, req_valid;
  logic [2:0] req_idx;

  logic [7:0] irq_l, mask_l;
  logic       ack_l;
  logic [7:0] pend_o_l;
  logic       pend_any_l, req_valid_l;
  logic [2:0] req_idx_l;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] pend;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_lq[$];
  exp_t e_m, e_lm;
  logic prev_v  = 1'b0;
  logic prev_lv = 1'b0;

  always #5 clk = ~clk;

  irq_request_latch #(.EDGE(1'b1), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .ack(ack),
    .pend_o(pend_o), .pend_any(pend_any), .req_valid(req_valid), .req_idx(req_idx)
  );

  irq_request_latch #(.EDGE(1'b0), .SYNC_STAGES(2)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_l), .mask(mask_l), .ack(ack_l),
    .pend_o(pend_o_l), .pend_any(pend_any_l), .req_valid(req_valid_l), .req_idx(req_idx_l)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grant(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: got no grant within 20 cycles, expected a grant", name);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Edge-mode monitor: each new grant is compared against the scoreboard head.
  always @(negedge clk) begin
    if (req_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got idx %0d, expected no grant", req_idx);
      end else begin
        e_m = exp_q.pop_front();
        check8("grant_idx", {5'd0, req_idx}, {5'd0, e_m.idx});
        check8("grant_pend_o", pend_o, e_m.pend);
      end
    end
    prev_v <= req_valid;
  end

  // Level-mode monitor.
  always @(negedge clk) begin
    if (req_valid_l && !prev_lv) begin
      if (exp_lq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant_lvl: got idx %0d, expected no grant", req_idx_l);
      end else begin
        e_lm = exp_lq.pop_front();
        check8("grant_idx_lvl", {5'd0, req_idx_l}, {5'd0, e_lm.idx});
        check8("grant_pend_o_lvl", pend_o_l, e_lm.pend);
      end
    end
    prev_lv <= req_valid_l;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst_n  = 1'b0;
    irq_in = 8'hFF;
    mask   = 8'hFF;
    ack    = 1'b0;
    irq_l  = 8'hFF;
    mask_l = 8'hFF;
    ack_l  = 1'b0;
    tick(3);
    check8("rst_pend_o", pend_o, 8'h00);
    check8("rst_pend_any", {7'd0, pend_any}, 8'h00);
    check8("rst_req_valid", {7'd0, req_valid}, 8'h00);
    check8("rst_req_idx", {5'd0, req_idx}, 8'h00);
    check8("rst_pend_o_lvl", pend_o_l, 8'h00);
    check8("rst_req_valid_lvl", {7'd0, req_valid_l}, 8'h00);

    irq_in = 8'h00;
    irq_l  = 8'h00;
    rst_n  = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_valid || pend_any) bad++;
    end
    check8("idle_after_reset", 8'(bad), 8'h00);

    // Single edge: grant exactly four edges after the line rises.
    exp_q.push_back('{idx: 3'd3, pend: 8'h08});
    irq_in = 8'h08;
    tick(3);
    check8("latency_e3", {7'd0, req_valid}, 8'h00);
    tick(1);
    check8("latency_e4", {7'd0, req_valid}, 8'h01);
    do_ack();
    check8("ack_drops_valid", {7'd0, req_valid}, 8'h00);
    tick(1);
    check8("ack_clears_pend_o", pend_o, 8'h00);
    tick(5);
    check8("no_regrant", {7'd0, req_valid}, 8'h00);
    irq_in = 8'h00;
    tick(4);

    // Priority ordering: bit 6 first, then bit 1.
    exp_q.push_back('{idx: 3'd6, pend: 8'h42});
    exp_q.push_back('{idx: 3'd1, pend: 8'h02});
    irq_in = 8'h42;
    wait_grant("prio_first");
    do_ack();
    wait_grant("prio_second");
    do_ack();
    tick(3);
    check8("prio_done_pend_o", pend_o, 8'h00);
    check8("prio_done_valid", {7'd0, req_valid}, 8'h00);
    irq_in = 8'h00;
    tick(4);

    // Masked request stays pending and is granted once unmasked.
    mask   = 8'hF7;
    irq_in = 8'h08;
    tick(8);
    check8("masked_no_grant", {7'd0, req_valid}, 8'h00);
    check8("masked_pend_o", pend_o, 8'h00);
    exp_q.push_back('{idx: 3'd3, pend: 8'h08});
    mask = 8'hFF;
    tick(2);
    check8("unmask_grant", {7'd0, req_valid}, 8'h01);
    do_ack();
    irq_in = 8'h00;
    tick(4);

    // New rise on the granted bit in the ack cycle keeps it pending.
    exp_q.push_back('{idx: 3'd5, pend: 8'h20});
    irq_in = 8'h20;
    wait_grant("setclr_first");
    irq_in = 8'h00;
    tick(4);
    exp_q.push_back('{idx: 3'd5, pend: 8'h20});
    irq_in = 8'h20;
    tick(2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check8("setclr_ack_valid", {7'd0, req_valid}, 8'h00);
    wait_grant("setclr_regrant");
    do_ack();
    tick(3);
    check8("setclr_final_pend_o", pend_o, 8'h00);
    irq_in = 8'h00;
    tick(4);

    // Reset in the middle of a handshake, both modes.
    exp_q.push_back('{idx: 3'd7, pend: 8'h81});
    exp_lq.push_back('{idx: 3'd7, pend: 8'h81});
    irq_in = 8'h81;
    irq_l  = 8'h81;
    wait_grant("midrst_grant");
    tick(2);
    check8("midrst_lvl_valid_before", {7'd0, req_valid_l}, 8'h01);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check8("midrst_valid", {7'd0, req_valid}, 8'h00);
    check8("midrst_pend_o", pend_o, 8'h00);
    check8("midrst_pend_any", {7'd0, pend_any}, 8'h00);
    check8("midrst_valid_lvl", {7'd0, req_valid_l}, 8'h00);
    check8("midrst_pend_o_lvl", pend_o_l, 8'h00);
    tick(3);
    exp_lq.push_back('{idx: 3'd7, pend: 8'h81});
    rst_n = 1'b1;
    tick(20);
    check8("post_rst_edge_valid", {7'd0, req_valid}, 8'h00);
    check8("post_rst_edge_pend_o", pend_o, 8'h00);
    check8("post_rst_lvl_valid", {7'd0, req_valid_l}, 8'h01);
    check8("post_rst_lvl_idx", {5'd0, req_idx_l}, 8'h07);

    tick(2);
    check8("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    check8("scoreboard_lvl_drained", 8'(exp_lq.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
